alu_sequencer: RTL and testbench

Multi-cycle sequencer for the execute stage. It accepts one ALU operation per handshake and drives the combinational single-step ALU, which sits outside this block. Non-shift operations complete in one ALU pass. Shifts are performed as shamt successive 1-bit ALU passes, with the partial result fed back each cycle. The final result is returned on a valid/ready output port.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, op codes, sequencer states and
// op-class helpers keyed on the 4-bit {funct3, funct7[5]} code.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int SHW  = $clog2(XLEN);

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_SLTU = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'hA;
    localparam logic [3:0] OP_SRA  = 4'hB;
    localparam logic [3:0] OP_OR   = 4'hC;
    localparam logic [3:0] OP_AND  = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
    endfunction

    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLT, OP_SLTU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Execute-stage sequencer around an external single-step ALU; shifts run as
// shamt 1-bit passes. Define ALU_SEQ_ILLEGAL_CHK_EN to flag illegal op codes.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            out_err,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic [XLEN-1:0] alu_s1,
    output logic [XLEN-1:0] alu_s2,
    input  logic [XLEN-1:0] alu_res
);

    state_t          state;
    logic [2:0]      f3;
    logic            f7b5;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic [SHW-1:0]  cnt;

    logic [3:0]      in_code;
    logic [SHW-1:0]  in_shamt;
    logic            unused_f7;

    assign in_code   = {in_funct3, in_funct7[5]};
    assign in_shamt  = in_b[SHW-1:0];
    assign unused_f7 = ^{in_funct7[6], in_funct7[4:0]};

    // ALU operands come straight from registers so they stay deterministic
    // outside EXEC/SHIFT.
    assign alu_funct3 = f3;
    assign alu_funct7 = {1'b0, f7b5, 5'b0};
    assign alu_s1     = acc;
    assign alu_s2     = b;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_res   = res;

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    logic err;
    assign out_err = err;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            f3    <= '0;
            f7b5  <= 1'b0;
            acc   <= '0;
            b     <= '0;
            res   <= '0;
            cnt   <= '0;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
            err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        f3   <= in_funct3;
                        f7b5 <= in_funct7[5];
                        acc  <= in_a;
                        b    <= in_b;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
                        err  <= 1'b0;
`endif
                        if (is_shift(in_code)) begin
                            if (in_shamt == '0) begin
                                res   <= in_a;
                                state <= DONE;
                            end else begin
                                cnt   <= in_shamt;
                                state <= SHIFT;
                            end
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
                        end else if (!is_legal(in_code)) begin
                            res   <= '0;
                            err   <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    res   <= alu_res;
                    state <= DONE;
                end
                SHIFT: begin
                    acc <= alu_res;
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        res   <= alu_res;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + light random bench for alu_sequencer with a 1-bit-shift ALU
// model beside it and a scoreboard of expected results and latencies.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_funct3 = '0;
    logic [6:0]      in_funct7 = '0;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_res;
    logic            out_err;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_s1;
    logic [XLEN-1:0] alu_s2;
    logic [XLEN-1:0] alu_res;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_err(out_err),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_res(alu_res)
    );

    always #5 clk = ~clk;

    // Single-step ALU: shift ops move exactly one bit per pass.
    always_comb begin
        alu_res = '0;
        case (alu_funct3)
            3'b000: alu_res = alu_funct7[5] ? alu_s1 - alu_s2 : alu_s1 + alu_s2;
            3'b001: alu_res = {alu_s1[30:0], 1'b0};
            3'b010: alu_res = {31'd0, $signed(alu_s1) < $signed(alu_s2)};
            3'b011: alu_res = {31'd0, alu_s1 < alu_s2};
            3'b100: alu_res = alu_s1 ^ alu_s2;
            3'b101: alu_res = alu_funct7[5] ? {alu_s1[31], alu_s1[31:1]} : {1'b0, alu_s1[31:1]};
            3'b110: alu_res = alu_s1 | alu_s2;
            default: alu_res = alu_s1 & alu_s2;
        endcase
    end

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Whole-operation reference, independent of the pass-by-pass ALU model.
    function automatic exp_t ref_op(input logic [2:0] f3, input logic f7b5,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [3:0] code;
        logic [4:0] sh;
        code = {f3, f7b5};
        sh = b[4:0];
        e.err = 1'b0;
        e.lat = 2;
        case (code)
            4'h0: e.res = a + b;
            4'h1: e.res = a - b;
            4'h2: e.res = a << sh;
            4'h4: e.res = {31'd0, $signed(a) < $signed(b)};
            4'h6: e.res = {31'd0, a < b};
            4'hA: e.res = a >> sh;
            4'hB: e.res = $signed(a) >>> sh;
            4'hC: e.res = a | b;
            4'hE: e.res = a & b;
            default: e.res = a ^ b;
        endcase
        if (code == 4'h2 || code == 4'hA || code == 4'hB)
            e.lat = (sh == 0) ? 1 : int'(sh) + 1;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
        else if (!(code inside {4'h0, 4'h1, 4'h4, 4'h6, 4'h8, 4'hC, 4'hE})) begin
            e.res = '0;
            e.err = 1'b1;
            e.lat = 1;
        end
`endif
        return e;
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        exp_t e;
        int lat;
        bit got;
        e = ref_op(f3, f7[5], a, b);
        @(negedge clk);
        chk({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
        out_ready = (hold == 0);
        in_valid = 1'b1;
        in_funct3 = f3;
        in_funct7 = f7;
        in_a = a;
        in_b = b;
        @(posedge clk);
        sb.push_back(e);
        #1 in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else begin
                lat++;
                chk({tag, ":alu_funct3"}, {29'd0, alu_funct3}, {29'd0, f3});
                chk({tag, ":alu_funct7"}, {25'd0, alu_funct7}, {25'd0, 1'b0, f7[5], 5'd0});
            end
        end
        e = sb.pop_front();
        if (!got) begin
            chk({tag, ":timeout"}, {31'd0, out_valid}, 32'd1);
            out_ready = 1'b1;
            return;
        end
        chk({tag, ":res"}, out_res, e.res);
        chk({tag, ":err"}, {31'd0, out_err}, {31'd0, e.err});
        chk({tag, ":lat"}, 32'(lat), 32'(e.lat));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ":hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ":hold_res"}, out_res, e.res);
            chk({tag, ":hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ":handoff_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ":handoff_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rf3;
        logic [6:0] rf7;
        logic [3:0] codes [7];
        int seen;
        codes = '{4'h0, 4'h1, 4'h4, 4'h6, 4'h8, 4'hC, 4'hE};

        #3;
        chk("rst:in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst:out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst:out_res", out_res, 32'd0);
        chk("rst:out_err", {31'd0, out_err}, 32'd0);
        chk("rst:alu_funct3", {29'd0, alu_funct3}, 32'd0);
        chk("rst:alu_funct7", {25'd0, alu_funct7}, 32'd0);
        chk("rst:alu_s1", alu_s1, 32'd0);
        chk("rst:alu_s2", alu_s2, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(3'b000, 7'h00, 32'd5, 32'd7, 0, "add");
        issue(3'b000, 7'h20, 32'd3, 32'd5, 0, "sub");
        issue(3'b001, 7'h00, 32'd1, 32'd31, 0, "sll31");
        issue(3'b101, 7'h20, 32'h8000_0000, 32'h24, 0, "sra4");
        issue(3'b101, 7'h00, 32'h1234, 32'd0, 0, "srl0");
        issue(3'b101, 7'h00, 32'hF000_000F, 32'hFFFF_FFE3, 0, "srl3_upper");
        issue(3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 0, "slt");
        issue(3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
        issue(3'b100, 7'h20, 32'h00FF_00FF, 32'h0F0F_0F0F, 0, "illegal");
        issue(3'b110, 7'h00, 32'hA5A5_0000, 32'h0000_5A5A, 3, "or_bp");
        issue(3'b001, 7'h00, 32'h0000_0003, 32'd2, 2, "sll_bp");

        // Reset in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1;
        in_funct3 = 3'b001;
        in_funct7 = 7'h00;
        in_a = 32'd1;
        in_b = 32'd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst:in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst:alu_s1", alu_s1, 32'd0);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst:stale", 32'(seen), 32'd0);
        issue(3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1, 0, "add_after_rst");

        for (int k = 0; k < 8; k++) begin
            logic [3:0] c;
            c = codes[$urandom_range(0, 6)];
            rf3 = c[3:1];
            rf7 = {1'b0, c[0], 5'd0};
            issue(rf3, rf7, $urandom, $urandom, 0, "rand_alu");
        end
        for (int k = 0; k < 4; k++) begin
            rf7 = {1'b0, 1'($urandom_range(0, 1)), 5'd0};
            issue(3'b101, rf7, $urandom, $urandom, 0, "rand_sr");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
